// File: rtl/modexp_host_driver.sv
// Host-side initiator for the 4096-bit modexp core: buffers the base operand,
// loads and runs the core, captures the result and drains it to the host.

`ifndef WAIT_COMPUTE
`define WAIT_COMPUTE 5'd3
`endif
`ifndef COMPLETE
`define COMPLETE 5'd5
`endif
`ifndef OUTPUT_RESULT
`define OUTPUT_RESULT 5'd6
`endif

module modexp_host_driver #(
  parameter int         DATA_WIDTH       = 128,
  parameter int         TOTAL_ADDR       = 32,
  parameter logic [4:0] ST_WAIT_COMPUTE  = `WAIT_COMPUTE,
  parameter logic [4:0] ST_COMPLETE      = `COMPLETE,
  parameter logic [4:0] ST_OUTPUT_RESULT = `OUTPUT_RESULT,
  parameter int         TIMEOUT_CYCLES   = 2**26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  core_rst,
  output logic                  core_startInput,
  output logic                  core_startCompute,
  output logic                  core_getResult,
  output logic [DATA_WIDTH-1:0] core_inp,
  input  logic [4:0]            core_state,
  input  logic [DATA_WIDTH-1:0] core_outp
);
  localparam int             KW      = $clog2(TOTAL_ADDR);
  localparam int             WDW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [KW-1:0]  K_LAST  = KW'(TOTAL_ADDR - 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, CRST, FILL, KICK, STREAM, PAD, WAIT_WC, WAIT_DONE, CAPTURE, DRAIN
  } state_t;

  state_t                state;
  logic [KW-1:0]         k;
  logic [WDW-1:0]        wd;
  logic                  cap_en;
  logic                  rst_hold;
  logic [DATA_WIDTH-1:0] in_buf  [TOTAL_ADDR];
  logic [DATA_WIDTH-1:0] out_buf [TOTAL_ADDR];
  logic                  watched, wd_fire, in_we, cap_we;

  assign watched = state inside {WAIT_WC, WAIT_DONE, CAPTURE};
  assign wd_fire = watched && (wd == WD_LAST);
  assign in_we   = (state == FILL) && in_valid;
  assign cap_we  = (state == CAPTURE) && cap_en && !wd_fire;

  // Operand buffers carry no reset; their contents are meaningless outside a job.
  always_ff @(posedge clk) begin
    if (in_we)  in_buf[k]  <= in_data;
    if (cap_we) out_buf[k] <= core_outp;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      k                 <= '0;
      wd                <= '0;
      cap_en            <= 1'b0;
      rst_hold          <= 1'b0;
      in_ready          <= 1'b0;
      out_valid         <= 1'b0;
      out_data          <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      timeout           <= 1'b0;
      core_rst          <= 1'b0;
      core_startInput   <= 1'b0;
      core_startCompute <= 1'b0;
      core_getResult    <= 1'b0;
      core_inp          <= '0;
    end else begin
      done <= 1'b0;
      if (wd_fire) begin
        // Abort: core_rst is held one more cycle from IDLE via rst_hold.
        timeout           <= 1'b1;
        core_rst          <= 1'b1;
        rst_hold          <= 1'b1;
        busy              <= 1'b0;
        core_startCompute <= 1'b0;
        core_getResult    <= 1'b0;
        cap_en            <= 1'b0;
        k                 <= '0;
        state             <= IDLE;
      end else begin
        if (watched) wd <= wd + 1'b1;
        unique case (state)
          IDLE: begin
            if (cmd_start) begin
              timeout  <= 1'b0;
              core_rst <= 1'b1;
              rst_hold <= 1'b0;
              busy     <= 1'b1;
              k        <= '0;
              state    <= CRST;
            end else if (rst_hold) begin
              rst_hold <= 1'b0;
            end else begin
              core_rst <= 1'b0;
            end
          end
          CRST: begin
            if (k == KW'(1)) begin
              k        <= '0;
              core_rst <= 1'b0;
              in_ready <= 1'b1;
              state    <= FILL;
            end else begin
              k <= k + 1'b1;
            end
          end
          FILL: begin
            if (in_valid) begin
              if (k == K_LAST) begin
                k               <= '0;
                in_ready        <= 1'b0;
                core_startInput <= 1'b1;
                state           <= KICK;
              end else begin
                k <= k + 1'b1;
              end
            end
          end
          KICK: begin
            core_startInput <= 1'b0;
            core_inp        <= in_buf[0];
            k               <= KW'(1);
            state           <= STREAM;
          end
          STREAM: begin
            core_inp <= in_buf[k];
            if (k == K_LAST) begin
              k     <= '0;
              state <= PAD;
            end else begin
              k <= k + 1'b1;
            end
          end
          PAD: begin
            // Core captures one word past the operand; feed it a zero.
            core_inp <= '0;
            wd       <= '0;
            state    <= WAIT_WC;
          end
          WAIT_WC: begin
            if (core_state == ST_WAIT_COMPUTE) begin
              core_startCompute <= 1'b1;
              state             <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            core_startCompute <= 1'b0;
            cap_en            <= 1'b0;
            if (core_state == ST_COMPLETE) begin
              core_getResult <= 1'b1;
              state          <= CAPTURE;
            end
          end
          CAPTURE: begin
            // core_outp lags the OUTPUT_RESULT state by one cycle.
            core_getResult <= 1'b0;
            cap_en         <= (core_state == ST_OUTPUT_RESULT);
            if (cap_en) begin
              if (k == K_LAST) begin
                k         <= '0;
                out_valid <= 1'b1;
                out_data  <= out_buf[0];
                state     <= DRAIN;
              end else begin
                k <= k + 1'b1;
              end
            end
          end
          DRAIN: begin
            if (out_ready) begin
              if (k == K_LAST) begin
                k         <= '0;
                out_valid <= 1'b0;
                done      <= 1'b1;
                busy      <= 1'b0;
                state     <= IDLE;
              end else begin
                k        <= k + 1'b1;
                out_data <= out_buf[k + 1'b1];
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
